// File: rtl/csr_weight_buffer.sv
// csr_weight_buffer: per-row compressed weight store with sparse/dense row streaming and random lookup.
// Build option CSR_BUF_STATS_EN adds saturating slot/zero-column statistics counters.
// Handshakes: a write or beat transfers on a rising edge where valid and ready are both high; the valid side holds its payload until then.

module csr_weight_buffer #(
  parameter int WORD_SIZE = 64,
  parameter int NUM_ROWS  = 64,
  parameter int ROW_DEPTH = 64,
  parameter int MAX_NNZ   = 32,
  parameter int IDX_W     = $clog2(ROW_DEPTH),
  parameter int PTR_W     = $clog2(MAX_NNZ) + 1,
  parameter int ROW_W     = $clog2(NUM_ROWS)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 wr_valid_i,
  output logic                 wr_ready_o,
  input  logic [ROW_W-1:0]     wr_row_i,
  input  logic [IDX_W-1:0]     wr_col_i,
  input  logic [WORD_SIZE-1:0] wr_data_i,
  input  logic                 rd_start_i,
  input  logic [ROW_W-1:0]     rd_row_i,
  input  logic                 rd_dense_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [IDX_W-1:0]     out_col_o,
  output logic [WORD_SIZE-1:0] out_data_o,
  output logic                 out_last_o,
  output logic [PTR_W-1:0]     rd_nnz_o,
  output logic                 rd_done_o,
  input  logic                 lk_en_i,
  input  logic [ROW_W-1:0]     lk_row_i,
  input  logic [IDX_W-1:0]     lk_col_i,
  output logic                 lk_valid_o,
  output logic [WORD_SIZE-1:0] lk_data_o,
  output logic                 err_overflow_o,
  output logic                 err_order_o,
  output logic [31:0]          mon_stored_nnz_o,
  output logic [31:0]          mon_zero_cols_o,
  output logic [1:0]           dbg_state_o
);

  localparam int SLOT_W = PTR_W - 1;
  localparam int CNT_W  = IDX_W + 1;
  localparam logic [PTR_W-1:0] SENT = {PTR_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_SPARSE, S_DENSE, S_DRAIN} state_e;

  logic [PTR_W-1:0]     nnz_q      [NUM_ROWS];
  logic [IDX_W-1:0]     last_col_q [NUM_ROWS];
  logic [NUM_ROWS-1:0]  started_q;
  logic [PTR_W-1:0]     ptr_q      [NUM_ROWS][ROW_DEPTH];
  logic [WORD_SIZE-1:0] slot_val_q [NUM_ROWS][MAX_NNZ];
  logic [IDX_W-1:0]     slot_col_q [NUM_ROWS][MAX_NNZ];
  logic                 err_ovf_q, err_order_q;

  logic [PTR_W-1:0] wr_cur_nnz, wr_ptr;
  logic wr_fire, wr_order_bad, wr_accept, wr_nonzero, wr_alloc, wr_ovf;

  state_e               state_q, state_d;
  logic [ROW_W-1:0]     rd_row_q, rd_row_d;
  logic [CNT_W-1:0]     idx_q, idx_d;
  logic [PTR_W-1:0]     rd_nnz_q, rd_nnz_d;
  logic                 out_valid_q, out_valid_d, out_last_q, out_last_d, rd_done_q, rd_done_d;
  logic [IDX_W-1:0]     out_col_q, out_col_d;
  logic [WORD_SIZE-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]     beat_total;
  logic [PTR_W-1:0]     dense_ptr, lk_ptr;
  logic [IDX_W-1:0]     beat_col;
  logic [WORD_SIZE-1:0] beat_data;
  logic                 beat_last, lk_hit, lk_valid_q;
  logic [WORD_SIZE-1:0] lk_data_q;

  // A pending read start takes priority over a write in the same cycle.
  assign wr_ready_o = !reset_i && (state_q == S_IDLE) && !rd_start_i;

  always_comb begin
    wr_fire      = wr_valid_i && wr_ready_o;
    wr_cur_nnz   = (wr_col_i == '0) ? '0 : nnz_q[wr_row_i];
    wr_order_bad = (wr_col_i != '0) &&
                   (!started_q[wr_row_i] || (wr_col_i <= last_col_q[wr_row_i]));
    wr_accept    = wr_fire && !wr_order_bad;
    wr_nonzero   = (wr_data_i != '0);
    wr_alloc     = wr_accept && wr_nonzero && (wr_cur_nnz < PTR_W'(MAX_NNZ));
    wr_ovf       = wr_accept && wr_nonzero && (wr_cur_nnz >= PTR_W'(MAX_NNZ));
    wr_ptr       = wr_alloc ? wr_cur_nnz : SENT;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      started_q   <= '0;
      err_ovf_q   <= 1'b0;
      err_order_q <= 1'b0;
      for (int r = 0; r < NUM_ROWS; r++) nnz_q[r] <= '0;
    end else begin
      if (wr_fire && wr_order_bad) err_order_q <= 1'b1;
      if (wr_ovf) err_ovf_q <= 1'b1;
      if (wr_accept) begin
        started_q[wr_row_i] <= 1'b1;
        nnz_q[wr_row_i]     <= wr_cur_nnz + PTR_W'(wr_alloc);
      end
    end
  end

  // Storage arrays need no reset: an unstarted row is masked, and column 0 re-fills its pointers.
  always_ff @(posedge clk_i) begin
    if (wr_accept) begin
      if (wr_col_i == '0) begin
        for (int c = 0; c < ROW_DEPTH; c++) ptr_q[wr_row_i][c] <= SENT;
      end
      ptr_q[wr_row_i][wr_col_i] <= wr_ptr;
      last_col_q[wr_row_i]      <= wr_col_i;
    end
    if (wr_alloc) begin
      slot_val_q[wr_row_i][wr_cur_nnz[SLOT_W-1:0]] <= wr_data_i;
      slot_col_q[wr_row_i][wr_cur_nnz[SLOT_W-1:0]] <= wr_col_i;
    end
  end

  always_comb begin
    lk_ptr = ptr_q[lk_row_i][lk_col_i];
    lk_hit = started_q[lk_row_i] && (lk_ptr != SENT);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lk_valid_q <= 1'b0;
      lk_data_q  <= '0;
    end else begin
      lk_valid_q <= lk_en_i;
      if (lk_en_i) lk_data_q <= lk_hit ? slot_val_q[lk_row_i][lk_ptr[SLOT_W-1:0]] : '0;
    end
  end

  always_comb begin
    beat_total = (state_q == S_DENSE) ? CNT_W'(ROW_DEPTH) : CNT_W'(rd_nnz_q);
    dense_ptr  = ptr_q[rd_row_q][idx_q[IDX_W-1:0]];
    beat_last  = (idx_q == beat_total - CNT_W'(1));
    if (state_q == S_DENSE) begin
      beat_col  = idx_q[IDX_W-1:0];
      beat_data = (started_q[rd_row_q] && (dense_ptr != SENT)) ?
                  slot_val_q[rd_row_q][dense_ptr[SLOT_W-1:0]] : '0;
    end else begin
      beat_col  = slot_col_q[rd_row_q][idx_q[SLOT_W-1:0]];
      beat_data = slot_val_q[rd_row_q][idx_q[SLOT_W-1:0]];
    end
  end

  always_comb begin
    state_d     = state_q;
    rd_row_d    = rd_row_q;
    idx_d       = idx_q;
    rd_nnz_d    = rd_nnz_q;
    out_valid_d = out_valid_q;
    out_col_d   = out_col_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    rd_done_d   = 1'b0;
    if (out_valid_q && out_ready_i) out_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rd_start_i) begin
          rd_row_d = rd_row_i;
          rd_nnz_d = nnz_q[rd_row_i];
          idx_d    = '0;
          state_d  = rd_dense_i ? S_DENSE : S_SPARSE;
        end
      end
      S_SPARSE, S_DENSE: begin
        if (beat_total == '0) begin
          state_d   = S_IDLE;
          rd_done_d = 1'b1;
        end else if (!out_valid_q || out_ready_i) begin
          out_valid_d = 1'b1;
          out_col_d   = beat_col;
          out_data_d  = beat_data;
          out_last_d  = beat_last;
          idx_d       = idx_q + CNT_W'(1);
          if (beat_last) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_valid_q && out_ready_i) begin
          state_d    = S_IDLE;
          rd_done_d  = 1'b1;
          out_last_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      rd_row_q    <= '0;
      idx_q       <= '0;
      rd_nnz_q    <= '0;
      out_valid_q <= 1'b0;
      out_col_q   <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      rd_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_row_q    <= rd_row_d;
      idx_q       <= idx_d;
      rd_nnz_q    <= rd_nnz_d;
      out_valid_q <= out_valid_d;
      out_col_q   <= out_col_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      rd_done_q   <= rd_done_d;
    end
  end

`ifdef CSR_BUF_STATS_EN
  logic [31:0] mon_stored_q, mon_zero_q;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mon_stored_q <= '0;
      mon_zero_q   <= '0;
    end else begin
      if (wr_alloc && (mon_stored_q != '1)) mon_stored_q <= mon_stored_q + 32'd1;
      if (wr_accept && !wr_nonzero && (mon_zero_q != '1)) mon_zero_q <= mon_zero_q + 32'd1;
    end
  end
  assign mon_stored_nnz_o = mon_stored_q;
  assign mon_zero_cols_o  = mon_zero_q;
`else
  assign mon_stored_nnz_o = '0;
  assign mon_zero_cols_o  = '0;
`endif

  assign out_valid_o    = out_valid_q;
  assign out_col_o      = out_col_q;
  assign out_data_o     = out_data_q;
  assign out_last_o     = out_last_q;
  assign rd_nnz_o       = rd_nnz_q;
  assign rd_done_o      = rd_done_q;
  assign lk_valid_o     = lk_valid_q;
  assign lk_data_o      = lk_data_q;
  assign err_overflow_o = err_ovf_q;
  assign err_order_o    = err_order_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_csr_weight_buffer.sv
// Self-checking bench for csr_weight_buffer: random writes/reads/lookups scored against a dense per-row model.
// Expected beats and lookups are queued at issue time and consumed by a monitor on each DUT handshake.

module tb_csr_weight_buffer;
  localparam int W = 64, NR = 64, RD = 64, MN = 32, IW = 6, PW = 6, RW = 6;

  logic          clk, reset;
  logic          wr_valid, wr_ready, rd_start, rd_dense, out_valid, out_ready, out_last;
  logic [RW-1:0] wr_row, rd_row, lk_row;
  logic [IW-1:0] wr_col, out_col, lk_col;
  logic [W-1:0]  wr_data, out_data, lk_data;
  logic [PW-1:0] rd_nnz;
  logic          rd_done, lk_en, lk_valid, err_overflow, err_order;
  logic [31:0]   mon_stored_nnz, mon_zero_cols;
  logic [1:0]    dbg_state;

  csr_weight_buffer dut (
    .clk_i(clk), .reset_i(reset),
    .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_row_i(wr_row), .wr_col_i(wr_col),
    .wr_data_i(wr_data), .rd_start_i(rd_start), .rd_row_i(rd_row), .rd_dense_i(rd_dense),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_col_o(out_col), .out_data_o(out_data),
    .out_last_o(out_last), .rd_nnz_o(rd_nnz), .rd_done_o(rd_done),
    .lk_en_i(lk_en), .lk_row_i(lk_row), .lk_col_i(lk_col), .lk_valid_o(lk_valid), .lk_data_o(lk_data),
    .err_overflow_o(err_overflow), .err_order_o(err_order),
    .mon_stored_nnz_o(mon_stored_nnz), .mon_zero_cols_o(mon_zero_cols), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model: dense view of what each row holds
  logic [W-1:0] m_val [NR][RD];
  bit           m_kept[NR][RD];
  int           m_nnz [NR];
  int           m_last[NR];
  bit           m_started[NR];
  bit           m_err_ovf, m_err_order;
  longint       m_stored, m_zero;

  // scoreboard
  logic [W+IW:0] exp_q[$];
  logic [W-1:0]  lk_q[$];
  bit            done_q[$];
  int errors = 0, checks = 0;
  int last_hs_cyc = 0, beats_seen = 0, ready_mode = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      m_nnz[r] = 0; m_last[r] = 0; m_started[r] = 0;
      for (int c = 0; c < RD; c++) begin m_kept[r][c] = 0; m_val[r][c] = '0; end
    end
    m_err_ovf = 0; m_err_order = 0; m_stored = 0; m_zero = 0;
  endtask

  task automatic model_write(input int row, input int col, input logic [W-1:0] data);
    if (col != 0 && (!m_started[row] || col <= m_last[row])) begin
      m_err_order = 1;
      return;
    end
    if (col == 0) begin
      for (int c = 0; c < RD; c++) m_kept[row][c] = 0;
      m_nnz[row] = 0;
      m_started[row] = 1;
    end
    m_last[row] = col;
    if (data == '0) m_zero++;
    else if (m_nnz[row] < MN) begin
      m_kept[row][col] = 1; m_val[row][col] = data; m_nnz[row]++; m_stored++;
    end else m_err_ovf = 1;
  endtask

  // monitor
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      beats_seen++;
      last_hs_cyc = cyc;
      if (exp_q.size() == 0) chk("unexpected_beat", {out_last, out_col, out_data}, '0);
      else chk("beat", {out_last, out_col, out_data}, exp_q.pop_front());
    end
    if (rd_done) begin
      if (done_q.size() == 0) chk("unexpected_rd_done", 1, 0);
      else begin
        if (!done_q.pop_front()) chk("rd_done_latency", cyc, last_hs_cyc + 1);
        chk("rd_done_beats_left", exp_q.size(), 0);
      end
    end
    if (lk_valid) begin
      if (lk_q.size() == 0) chk("unexpected_lk_valid", 1, 0);
      else chk("lookup", lk_data, lk_q.pop_front());
    end
  end

  // out_ready driver: 0 = always ready, 1 = random, 2 = held by the main sequence
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (ready_mode == 0) out_ready = 1'b1;
      else if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
    end
  end

  // driver tasks (entered and left at posedge+1)
  task automatic wr(input int row, input int col, input logic [W-1:0] data);
    bit ok = 0;
    wr_valid = 1; wr_row = row[RW-1:0]; wr_col = col[IW-1:0]; wr_data = data;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk); ok = wr_ready;
      @(posedge clk); #1;
    end
    wr_valid = 0;
    if (!ok) chk("write_timeout", 0, 1);
    else model_write(row, col, data);
  endtask

  task automatic rd(input int row, input bit dense);
    int i = 0;
    logic [IW-1:0] cv;
    if (dense) begin
      for (int c = 0; c < RD; c++) begin
        cv = c[IW-1:0];
        exp_q.push_back({(c == RD - 1), cv, m_kept[row][c] ? m_val[row][c] : {W{1'b0}}});
      end
    end else begin
      for (int c = 0; c < RD; c++) if (m_kept[row][c]) begin
        cv = c[IW-1:0];
        exp_q.push_back({(i == m_nnz[row] - 1), cv, m_val[row][c]});
        i++;
      end
    end
    done_q.push_back(!dense && m_nnz[row] == 0);
    rd_start = 1; rd_row = row[RW-1:0]; rd_dense = dense;
    @(posedge clk); #1;
    rd_start = 0;
    chk("rd_nnz", rd_nnz, m_nnz[row]);
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 5000 && (exp_q.size() != 0 || done_q.size() != 0); t++) begin
      @(posedge clk); #1;
    end
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      chk("drain_timeout", exp_q.size() + done_q.size(), 0);
      exp_q.delete(); done_q.delete();
    end
  endtask

  task automatic lk(input int row, input int col);
    lk_q.push_back((m_started[row] && m_kept[row][col]) ? m_val[row][col] : {W{1'b0}});
    lk_en = 1; lk_row = row[RW-1:0]; lk_col = col[IW-1:0];
    @(posedge clk); #1;
    lk_en = 0;
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, "_err_overflow"}, err_overflow, m_err_ovf);
    chk({tag, "_err_order"}, err_order, m_err_order);
`ifdef CSR_BUF_STATS_EN
    chk({tag, "_mon_stored"}, mon_stored_nnz, m_stored);
    chk({tag, "_mon_zero"}, mon_zero_cols, m_zero);
`else
    chk({tag, "_mon_stored"}, mon_stored_nnz, 0);
    chk({tag, "_mon_zero"}, mon_zero_cols, 0);
`endif
  endtask

  function automatic logic [W-1:0] rnd_word();
    return {$urandom, $urandom} | 64'h1;
  endfunction

  // main sequence
  initial begin
    int base, row, c;
    reset = 1; wr_valid = 0; wr_row = '0; wr_col = '0; wr_data = '0;
    rd_start = 0; rd_row = '0; rd_dense = 0; lk_en = 0; lk_row = '0; lk_col = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_wr_ready", wr_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_rd_done", rd_done, 0);
    chk("reset_lk_valid", lk_valid, 0);
    chk("reset_rd_nnz", rd_nnz, 0);
    chk("reset_outs", {out_col, out_data, lk_data}, 0);
    chk_flags("reset");
    reset = 0;
    #1 chk("post_reset_wr_ready", wr_ready, 1);

    // 75% sparse row, sparse then dense read
    for (int k = 0; k < RD; k++) wr(5, k, (k % 4 == 0) ? {W{1'b1}} : {W{1'b0}});
    rd(5, 0); wait_idle();
    chk_flags("sparse75");
    rd(5, 1); wait_idle();

    // overflow row and lookups around the slot limit
    for (int k = 0; k < RD; k++) wr(0, k, rnd_word());
    rd(0, 0); wait_idle();
    chk_flags("overflow");
    lk(0, 40); lk(0, 31); lk(5, 4); lk(5, 5); lk(0, 0);

    // backpressure on a 90% sparse row
    for (int k = 0; k < RD; k++) wr(12, k, (k % 10 == 0 && k < 60) ? rnd_word() : {W{1'b0}});
    ready_mode = 1;
    rd(12, 0); wait_idle();
    rd(12, 1); wait_idle();
    ready_mode = 0;

    // column order and restart
    wr(9, 0, rnd_word()); wr(9, 7, rnd_word());
    chk_flags("order_ok");
    wr(9, 3, rnd_word());
    chk_flags("order_bad");
    rd(9, 0); wait_idle();
    wr(9, 0, '0); wr(9, 2, rnd_word());
    rd(9, 0); wait_idle();
    rd(9, 1); wait_idle();
    wr(20, 5, rnd_word());
    lk(20, 5); lk(9, 7); lk(9, 2);

    // randomized rows, reads and lookups
    for (int k = 0; k < 4; k++) begin
      row = $urandom_range(30, 40);
      c = 0;
      while (c < RD) begin
        wr(row, c, ($urandom_range(0, 99) < 45) ? rnd_word() : {W{1'b0}});
        c += $urandom_range(1, 3);
      end
      wr(row, $urandom_range(1, 20), rnd_word());
      ready_mode = 1;
      rd(row, k[0]); wait_idle();
      rd(row, !k[0]); wait_idle();
      ready_mode = 0;
      for (int j = 0; j < 4; j++) lk(row, $urandom_range(0, RD - 1));
      chk_flags("random");
    end

    // reset while the third beat is stalled
    ready_mode = 2; out_ready = 1;
    base = beats_seen;
    rd(5, 0);
    for (int t = 0; t < 20 && beats_seen < base + 2; t++) begin
      @(posedge clk); #1;
    end
    out_ready = 0;
    chk("stall_beat_count", beats_seen, base + 2);
    repeat (2) @(posedge clk);
    #1;
    chk("stall_valid", out_valid, 1);
    if (exp_q.size() != 0) chk("stall_beat", {out_last, out_col, out_data}, exp_q[0]);
    else chk("stall_beat_missing", exp_q.size(), 1);
    exp_q.delete(); done_q.delete();
    reset = 1;
    @(posedge clk); #1;
    model_reset();
    chk("abort_out_valid", out_valid, 0);
    chk("abort_wr_ready", wr_ready, 0);
    chk("abort_rd_nnz", rd_nnz, 0);
    chk_flags("abort");
    reset = 0; ready_mode = 0;
    @(posedge clk); #1;
    rd(5, 0); wait_idle();
    rd(0, 0); wait_idle();
    rd(12, 0); wait_idle();
    rd(5, 1); wait_idle();
    lk(5, 0);

    repeat (5) @(posedge clk);
    #1;
    chk("final_exp_q_empty", exp_q.size(), 0);
    chk("final_lk_q_empty", lk_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #600000;
    checks++; errors++;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
